// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front-end: PC generation, credit-limited imem requests,
// in-order prefetch FIFO and redirect handling with stale-response dropping.
module riscv_fetch_unit #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = 16,
    parameter int unsigned INSTR_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam logic [PC_W-1:0]  PC_STEP = PC_W'(4);
    localparam logic [SUM_W-1:0] CREDITS = SUM_W'(DEPTH);

    logic [PC_W-1:0]    fetch_pc;
    logic [PC_W-1:0]    resp_pc;
    logic [PC_W-1:0]    target_pc;
    logic [INSTR_W-1:0] fifo_instr [DEPTH];
    logic [PC_W-1:0]    fifo_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   inflight;
    logic [CNT_W-1:0]   drop;
    logic               grant_c;
    logic               drop_c;
    logic               push_c;
    logic               pop_c;
    logic               unused_pc_bits;

    assign target_pc      = {redirect_pc[PC_W-1:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc[1:0];

    // Issue only while buffered + outstanding entries leave room in the FIFO
    assign imem_req  = reset && !redirect &&
                       ((SUM_W'(count) + SUM_W'(inflight)) < CREDITS);
    assign imem_addr = fetch_pc;
    assign grant_c   = imem_req && imem_gnt;

    // Responses are discarded during a redirect or while stale ones remain
    assign drop_c    = imem_rvalid && (redirect || (drop != '0));
    assign push_c    = imem_rvalid && !drop_c;

    assign out_valid = reset && (count != '0) && !redirect;
    assign pop_c     = out_valid && out_ready;
    assign out_instr = fifo_instr[rd_ptr];
    assign out_pc    = fifo_pc[rd_ptr];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc   <= '0;
            resp_pc    <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            inflight   <= '0;
            drop       <= '0;
            fifo_instr <= '{default: '0};
            fifo_pc    <= '{default: '0};
        end else begin
            inflight <= inflight + CNT_W'(grant_c) - CNT_W'(imem_rvalid);
            if (redirect) begin
                // Everything outstanding (minus one arriving now) becomes stale
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                count    <= '0;
                drop     <= drop + inflight - CNT_W'(imem_rvalid);
            end else begin
                if (grant_c) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (imem_rvalid && (drop != '0)) begin
                    drop <= drop - CNT_W'(1);
                end
                if (push_c) begin
                    fifo_instr[wr_ptr] <= imem_rdata;
                    fifo_pc[wr_ptr]    <= resp_pc;
                    wr_ptr             <= wr_ptr + PTR_W'(1);
                    resp_pc            <= resp_pc + PC_STEP;
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
            end
        end
    end

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit with an in-order, fixed-latency memory model.
module tb_riscv_fetch_unit;

    logic        clock       = 1'b0;
    logic        reset       = 1'b0;
    logic        redirect    = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt    = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        out_valid;
    logic        out_ready   = 1'b1;
    logic [31:0] out_instr;
    logic [15:0] out_pc;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int lat     = 1;

    typedef struct {
        logic [15:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    riscv_fetch_unit #(.DEPTH(4), .PC_W(16), .INSTR_W(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {a ^ 16'h5A5A, a};
    endfunction

    // Record grants mid-cycle; answer lat cycles later, one response per cycle
    always @(negedge clock) begin : record_grant
        pend_t e;
        if (reset && imem_req && imem_gnt) begin
            e.addr = imem_addr;
            e.due  = cyc + lat;
            pend.push_back(e);
        end
    end

    always begin
        @(posedge clock);
        #1;
        cyc++;
        if (!reset) begin
            pend.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns just after the edge that starts cycle 0 with reset released
    task automatic apply_reset();
        step();
        reset     = 1'b0;
        redirect  = 1'b0;
        out_ready = 1'b1;
        imem_gnt  = 1'b1;
        lat       = 1;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        step();
        reset    = 1'b0;
        redirect = 1'b0;
        #2;
        n_tests++;
        if ({imem_req, imem_addr, out_valid, out_instr, out_pc} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_values: got req=%b addr=%h v=%b instr=%h pc=%h, want all 0",
                     imem_req, imem_addr, out_valid, out_instr, out_pc);
        end
        step();
        reset = 1'b1;
        @(negedge clock);
        n_tests++;
        if ({imem_req, imem_addr} !== {1'b1, 16'h0000}) begin
            n_fail++;
            $display("FAIL reset_first_req: got req=%b addr=%h, want req=1 addr=0000",
                     imem_req, imem_addr);
        end
    endtask

    task automatic test_free_run();
        logic [15:0] pc;
        apply_reset();
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            n_tests++;
            if (k < 2) begin
                if (out_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL free_run_empty[%0d]: got v=%b, want v=0", k, out_valid);
                end
            end else begin
                pc = 16'((k - 2) * 4);
                if ({out_valid, out_pc, out_instr} !== {1'b1, pc, mem_word(pc)}) begin
                    n_fail++;
                    $display("FAIL free_run[%0d]: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                             k, out_valid, out_pc, out_instr, pc, mem_word(pc));
                end
            end
            step();
        end
    endtask

    task automatic test_stall();
        logic [15:0] pc;
        apply_reset();
        out_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            n_tests++;
            if (imem_req !== (k < 4)) begin
                n_fail++;
                $display("FAIL stall_req[%0d]: got req=%b, want %b", k, imem_req, (k < 4));
            end
            if (k >= 2) begin
                n_tests++;
                if ({out_valid, out_pc} !== {1'b1, 16'h0000}) begin
                    n_fail++;
                    $display("FAIL stall_head[%0d]: got v=%b pc=%h, want v=1 pc=0000",
                             k, out_valid, out_pc);
                end
            end
            step();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            pc = 16'(i * 4);
            n_tests++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, pc, mem_word(pc)}) begin
                n_fail++;
                $display("FAIL stall_release[%0d]: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, pc, mem_word(pc));
            end
            step();
        end
    endtask

    task automatic test_redirect_latency();
        logic [15:0] got_pc [2];
        logic [31:0] got_in [2];
        int          got_at [2];
        int          found;
        apply_reset();
        lat = 3;
        step();
        step();
        imem_gnt    = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 16'h0030;
        @(negedge clock);
        n_tests++;
        if ({imem_req, out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL redir3_cycle: got req=%b v=%b, want 0 0", imem_req, out_valid);
        end
        step();
        redirect = 1'b0;
        imem_gnt = 1'b1;
        found    = 0;
        for (int j = 0; j < 20 && found < 2; j++) begin
            @(negedge clock);
            if (j == 0) begin
                n_tests++;
                if ({imem_req, imem_addr} !== {1'b1, 16'h0030}) begin
                    n_fail++;
                    $display("FAIL redir3_req: got req=%b addr=%h, want 1 0030", imem_req, imem_addr);
                end
            end
            if (out_valid === 1'b1) begin
                got_pc[found] = out_pc;
                got_in[found] = out_instr;
                got_at[found] = j;
                found++;
            end
            step();
        end
        n_tests++;
        if (found != 2) begin
            n_fail++;
            $display("FAIL redir3_timeout: got %0d outputs, want 2", found);
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if ({got_pc[i], got_in[i]} !== {16'(16'h0030 + i * 4), mem_word(16'(16'h0030 + i * 4))}
                    || got_at[i] != 4 + i) begin
                    n_fail++;
                    $display("FAIL redir3_out[%0d]: got pc=%h instr=%h at %0d, want pc=%h at %0d",
                             i, got_pc[i], got_in[i], got_at[i], 16'(16'h0030 + i * 4), 4 + i);
                end
            end
        end
    endtask

    task automatic test_redirect_rvalid();
        apply_reset();
        out_ready = 1'b0;
        step();
        step();
        step();
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 16'h0100;
        @(negedge clock);
        n_tests++;
        if ({imem_req, out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL redir_rv_cycle: got req=%b v=%b, want 0 0", imem_req, out_valid);
        end
        step();
        redirect = 1'b0;
        @(negedge clock);
        n_tests++;
        if ({imem_req, imem_addr, out_valid} !== {1'b1, 16'h0100, 1'b0}) begin
            n_fail++;
            $display("FAIL redir_rv_r1: got req=%b addr=%h v=%b, want 1 0100 0",
                     imem_req, imem_addr, out_valid);
        end
        step();
        @(negedge clock);
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_rv_r2: got v=%b pc=%h, want v=0", out_valid, out_pc);
        end
        step();
        @(negedge clock);
        n_tests++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 16'h0100, mem_word(16'h0100)}) begin
            n_fail++;
            $display("FAIL redir_rv_r3: got v=%b pc=%h instr=%h, want v=1 pc=0100 instr=%h",
                     out_valid, out_pc, out_instr, mem_word(16'h0100));
        end
    endtask

    // Redirect at cycle 1, then check requests from R+1 and outputs from R+3
    task automatic test_redirect_target(input logic [15:0] tgt, input logic [15:0] want);
        logic [15:0] a;
        apply_reset();
        step();
        redirect    = 1'b1;
        redirect_pc = tgt;
        step();
        redirect = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            a = 16'(want + 16'(k * 4));
            if (k < 3) begin
                n_tests++;
                if ({imem_req, imem_addr} !== {1'b1, a}) begin
                    n_fail++;
                    $display("FAIL target_%h_req[%0d]: got req=%b addr=%h, want 1 %h",
                             tgt, k, imem_req, imem_addr, a);
                end
            end
            if (k >= 2) begin
                a = 16'(want + 16'((k - 2) * 4));
                n_tests++;
                if ({out_valid, out_pc, out_instr} !== {1'b1, a, mem_word(a)}) begin
                    n_fail++;
                    $display("FAIL target_%h_out[%0d]: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                             tgt, k, out_valid, out_pc, out_instr, a, mem_word(a));
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        repeat (4) step();
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({imem_req, imem_addr, out_valid, out_instr, out_pc} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got req=%b addr=%h v=%b instr=%h pc=%h, want all 0",
                     imem_req, imem_addr, out_valid, out_instr, out_pc);
        end
        step();
        reset = 1'b1;
        @(negedge clock);
        n_tests++;
        if ({imem_req, imem_addr, out_valid} !== {1'b1, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid_restart: got req=%b addr=%h v=%b, want 1 0000 0",
                     imem_req, imem_addr, out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect_latency();
        test_redirect_rvalid();
        test_redirect_target(16'hFFFC, 16'hFFFC);
        test_redirect_target(16'h0013, 16'h0010);
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
